rs_enc_framer: RTL and testbench
================================

// Module: rs_enc_framer
// PURPOSE
//  - Transmit-side front end of the RS encoder path. Takes 32-bit message words, serialises them
//    LSB-byte-first into 8-bit AXIS, and frames the stream into RS information blocks of K bytes.
//  - Drives tlast on the last byte of every block. When a message ends mid-block, pads the
//    remainder of the block with PAD_BYTE. Sits directly in front of the rs_encoder IP s_axis_input.
// PARAMETERS
//  K         223    information bytes per RS block (legal 1..255; must match encoder IP config)
//  PAD_BYTE  8'h00  fill byte emitted to complete a partial final block
// PORTS
//  core_clk         in   1   single clock for the whole block
//  rst_n            in   1   asynchronous reset, active-low
//  input_tdata      in   32  message word; byte0=[7:0] is sent first
//  input_tvalid     in   1   word valid
//  input_tlast      in   1   word is the last word of the message
//  input_tready     out  1   word accepted when input_tvalid && input_tready
//  m_axis_tdata     out  8   byte to encoder s_axis_input_tdata
//  m_axis_tvalid    out  1   byte valid
//  m_axis_tlast     out  1   last byte of a K-byte block
//  m_axis_tready    in   1   encoder s_axis_input_tready
//  pad_active       out  1   high while PAD bytes are being emitted
//  blocks_sent      out  16  count of blocks completed (tlast handshakes); wraps 0xFFFF->0
// BEHAVIOUR
//  - Reset (rst_n low, async): hold_vld=0, byte_idx=0, blk_cnt=0, msg_last=0, state=SHIFT,
//    rdy_en=0. Outputs m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, pad_active=0,
//    blocks_sent=0, input_tready=0. rdy_en sets on the first core_clk edge after deassertion.
//  - input_tready = rdy_en && state==SHIFT && (!hold_vld || (byte_idx==3 && m_axis_tready && !msg_last)).
//    This is a combinational path from m_axis_tready; it gives back-to-back words with no bubble.
//  - Word accept: latch tdata into hold, set hold_vld=1, byte_idx=0, msg_last=input_tlast.
//    The first byte is valid on the next cycle (latency 1).
//  - State SHIFT:
//    - m_axis_tvalid=hold_vld; m_axis_tdata=hold[8*byte_idx+:8]; m_axis_tlast=(blk_cnt==K-1).
//    - Each byte handshake: byte_idx++ and blk_cnt++. blk_cnt wraps K-1->0 on tlast.
//    - byte_idx==3 handshake: hold_vld clears unless a new word is accepted in the same cycle.
//    - Byte 3 of a msg_last word with blk_cnt!=K-1: go to PAD. With blk_cnt==K-1: stay in SHIFT;
//      that byte carries tlast and no padding is added.
//  - State PAD:
//    - m_axis_tvalid=1, m_axis_tdata=PAD_BYTE, pad_active=1, input_tready=0.
//    - Each handshake increments blk_cnt. The handshake with blk_cnt==K-1 carries tlast,
//      returns to SHIFT and clears msg_last.
//  - Blocks may straddle words; blk_cnt runs independently of byte_idx.
//  - AXIS rules: while m_axis_tvalid && !m_axis_tready, tdata and tlast are held stable.
//    tvalid never drops without a handshake.
//  - blocks_sent increments on every tlast handshake, whether the byte is data or pad.
//  - Reset mid-block or mid-PAD discards the partial block; after reset a new block starts at blk_cnt=0.
//  - Throughput with tvalid and tready held high: 1 byte/cycle, one input word accepted every 4 cycles.
// STRUCTURE
//  - enc_pkg:
//    - typedef enum {SHIFT, PAD} framer_state_t
//    - localparam RS_K_DEFAULT=223, RS_PAD_DEFAULT=8'h00
//    - function clog2-based width for blk_cnt
//  - One sub-module, word2byte_ser:
//    - contains hold register, byte_idx, hold_vld and the byte mux
//    - exposes last_byte_xfer to the framer FSM
//  - The top level keeps the FSM, blk_cnt, tlast generation and blocks_sent.
// TESTING (K=8 unless noted; m_axis_tready=1 unless noted)
//  1. Words 0x44332211, 0x88776655 (tlast on 2nd)
//     -> bytes 11..88; tlast only on 88; pad_active never high; blocks_sent=1.
//  2. Single word 0xDDCCBBAA with tlast
//     -> AA BB CC DD then 00 00 00 00; tlast on the 4th pad byte; input_tready=0 during pad.
//  3. K=6, words 0x04030201, 0x08070605, 0x0C0B0A09 (tlast on 3rd)
//     -> tlast on 06 and on 0C; no pad; blocks_sent=2.
//  4. Case 1 with m_axis_tready pattern 1,0,0,1 repeating
//     -> identical byte sequence; no drop or duplicate; tdata stable while stalled.
//  5. rst_n pulled low during the 2nd pad byte of case 2
//     -> next edge: tvalid=0, tlast=0, blocks_sent=0. Replay of case 1 yields a correct fresh block.
//  6. Continuous 8 words, no tlast, K=8
//     -> 32 consecutive byte handshakes with no idle cycle; tlast at bytes 8, 16, 24, 32; blocks_sent=4.

Source files
------------

// File: rtl/rs_enc_framer_pkg.sv
// Shared types and defaults for the RS encoder transmit framer.
// Imported by the framer top and its word-to-byte serialiser.
package rs_enc_framer_pkg;

    typedef enum logic [0:0] {
        SHIFT = 1'b0,
        PAD   = 1'b1
    } framer_state_t;

    localparam int         RS_K_DEFAULT   = 223;
    localparam logic [7:0] RS_PAD_DEFAULT = 8'h00;

    // Bits needed to count 0..k-1; never narrower than one bit so K=1 still elaborates.
    function automatic int blk_cnt_width(input int k);
        if (k < 2) begin
            return 1;
        end else begin
            return $clog2(k);
        end
    endfunction

endpackage

// File: rtl/rs_enc_framer_word2byte_ser.sv
// Holds one 32-bit message word and presents it a byte at a time, byte0 first.
// Reports the handshake of byte 3 so the framer knows when a word is finished.
module rs_enc_framer_word2byte_ser (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] word_data,
    input  logic        word_accept,
    input  logic        byte_xfer,
    output logic        hold_vld,
    output logic [1:0]  byte_idx,
    output logic [7:0]  byte_data,
    output logic        last_byte_xfer
);

    logic [31:0] hold_q;
    logic [31:0] hold_d;
    logic        hold_vld_q;
    logic        hold_vld_d;
    logic [1:0]  byte_idx_q;
    logic [1:0]  byte_idx_d;

    // Next hold/index: a new word has priority over the byte-3 release it replaces.
    always_comb begin
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        byte_idx_d = byte_idx_q;
        if (word_accept) begin
            hold_d     = word_data;
            hold_vld_d = 1'b1;
            byte_idx_d = 2'd0;
        end else if (byte_xfer) begin
            byte_idx_d = byte_idx_q + 2'd1;
            if (byte_idx_q == 2'd3) begin
                hold_vld_d = 1'b0;
            end else begin
                hold_vld_d = hold_vld_q;
            end
        end else begin
            hold_vld_d = hold_vld_q;
        end
    end

    // Serialiser state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q     <= 32'h0000_0000;
            hold_vld_q <= 1'b0;
            byte_idx_q <= 2'd0;
        end else begin
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            byte_idx_q <= byte_idx_d;
        end
    end

    // Byte select from the held word.
    always_comb begin
        byte_data = 8'h00;
        case (byte_idx_q)
            2'd0:    byte_data = hold_q[7:0];
            2'd1:    byte_data = hold_q[15:8];
            2'd2:    byte_data = hold_q[23:16];
            2'd3:    byte_data = hold_q[31:24];
            default: byte_data = 8'h00;
        endcase
    end

    assign hold_vld       = hold_vld_q;
    assign byte_idx       = byte_idx_q;
    assign last_byte_xfer = byte_xfer && (byte_idx_q == 2'd3);

endmodule

// File: rtl/rs_enc_framer.sv
// Serialises 32-bit message words into K-byte RS information blocks on an 8-bit AXIS,
// padding a short final block with PAD_BYTE and marking every block end with tlast.
module rs_enc_framer
    import rs_enc_framer_pkg::*;
#(
    parameter int         K        = RS_K_DEFAULT,
    parameter logic [7:0] PAD_BYTE = RS_PAD_DEFAULT
) (
    input  logic        core_clk,
    input  logic        rst_n,
    input  logic [31:0] input_tdata,
    input  logic        input_tvalid,
    input  logic        input_tlast,
    output logic        input_tready,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    output logic        m_axis_tlast,
    input  logic        m_axis_tready,
    output logic        pad_active,
    output logic [15:0] blocks_sent
);

    localparam int             BLK_W  = blk_cnt_width(K);
    localparam logic [BLK_W-1:0] K_LAST = BLK_W'(K - 1);

    framer_state_t    state_q;
    framer_state_t    state_d;
    logic [BLK_W-1:0] blk_cnt_q;
    logic [BLK_W-1:0] blk_cnt_d;
    logic [15:0]      blocks_sent_q;
    logic [15:0]      blocks_sent_d;
    logic             msg_last_q;
    logic             msg_last_d;
    logic             rdy_en_q;
    logic             rdy_en_d;

    logic             hold_vld_s;
    logic [1:0]       byte_idx_s;
    logic [7:0]       ser_byte_s;
    logic             last_byte_xfer_s;
    logic             word_accept_s;
    logic             byte_xfer_s;
    logic             axis_hs_s;
    logic             blk_at_last_s;
    logic             tvalid_s;
    logic [7:0]       tdata_s;
    logic             tready_s;

    assign blk_at_last_s = (blk_cnt_q == K_LAST);
    assign word_accept_s = input_tvalid && tready_s;
    assign byte_xfer_s   = (state_q == SHIFT) && hold_vld_s && m_axis_tready;
    assign axis_hs_s     = tvalid_s && m_axis_tready;

    rs_enc_framer_word2byte_ser u_ser (
        .clk            (core_clk),
        .rst_n          (rst_n),
        .word_data      (input_tdata),
        .word_accept    (word_accept_s),
        .byte_xfer      (byte_xfer_s),
        .hold_vld       (hold_vld_s),
        .byte_idx       (byte_idx_s),
        .byte_data      (ser_byte_s),
        .last_byte_xfer (last_byte_xfer_s)
    );

    // Output view per state; tready may take the next word in the same cycle byte 3 leaves.
    always_comb begin
        tvalid_s = 1'b0;
        tdata_s  = 8'h00;
        tready_s = 1'b0;
        case (state_q)
            SHIFT: begin
                tvalid_s = hold_vld_s;
                tdata_s  = ser_byte_s;
                tready_s = rdy_en_q && (!hold_vld_s ||
                           ((byte_idx_s == 2'd3) && m_axis_tready && !msg_last_q));
            end
            PAD: begin
                tvalid_s = 1'b1;
                tdata_s  = PAD_BYTE;
                tready_s = 1'b0;
            end
            default: begin
                tvalid_s = 1'b0;
                tdata_s  = 8'h00;
                tready_s = 1'b0;
            end
        endcase
    end

    // Block position, block counter and SHIFT/PAD sequencing.
    always_comb begin
        state_d       = state_q;
        msg_last_d    = msg_last_q;
        blk_cnt_d     = blk_cnt_q;
        blocks_sent_d = blocks_sent_q;
        rdy_en_d      = 1'b1;

        if (axis_hs_s) begin
            if (blk_at_last_s) begin
                blk_cnt_d     = {BLK_W{1'b0}};
                blocks_sent_d = blocks_sent_q + 16'd1;
            end else begin
                blk_cnt_d = blk_cnt_q + BLK_W'(1);
            end
        end else begin
            blk_cnt_d = blk_cnt_q;
        end

        case (state_q)
            SHIFT: begin
                if (word_accept_s) begin
                    msg_last_d = input_tlast;
                end else if (last_byte_xfer_s && msg_last_q) begin
                    // A message ending exactly on a block boundary needs no padding.
                    if (blk_at_last_s) begin
                        msg_last_d = 1'b0;
                    end else begin
                        state_d = PAD;
                    end
                end else begin
                    msg_last_d = msg_last_q;
                end
            end
            PAD: begin
                if (axis_hs_s && blk_at_last_s) begin
                    state_d    = SHIFT;
                    msg_last_d = 1'b0;
                end else begin
                    state_d = PAD;
                end
            end
            default: begin
                state_d = SHIFT;
            end
        endcase
    end

    // Framer state registers.
    always_ff @(posedge core_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= SHIFT;
            blk_cnt_q     <= {BLK_W{1'b0}};
            blocks_sent_q <= 16'h0000;
            msg_last_q    <= 1'b0;
            rdy_en_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            blk_cnt_q     <= blk_cnt_d;
            blocks_sent_q <= blocks_sent_d;
            msg_last_q    <= msg_last_d;
            rdy_en_q      <= rdy_en_d;
        end
    end

    assign input_tready  = tready_s;
    assign m_axis_tvalid = tvalid_s;
    assign m_axis_tdata  = tdata_s;
    assign m_axis_tlast  = tvalid_s && blk_at_last_s;
    assign pad_active    = (state_q == PAD);
    assign blocks_sent   = blocks_sent_q;

endmodule

// File: tb/tb_rs_enc_framer.sv
// Directed table-driven bench for rs_enc_framer: one K=8 instance and one K=6 instance.
module tb_rs_enc_framer;

    typedef struct {
        int                dut;
        int                nwords;
        logic [7:0][31:0]  w;
        logic              msg_last;
        logic [3:0]        rdy_pat;
        int                nbytes;
        logic [31:0][7:0]  exp_b;
        logic [31:0]       exp_last;
        logic [31:0]       exp_pad;
        int                exp_blocks;
        logic              no_gap;
    } vec_t;

    logic        clk;
    logic        rst_n_a    [2];
    logic [31:0] in_data_a  [2];
    logic        in_valid_a [2];
    logic        in_last_a  [2];
    logic        in_ready_a [2];
    logic [7:0]  m_data_a   [2];
    logic        m_valid_a  [2];
    logic        m_last_a   [2];
    logic        m_ready_a  [2];
    logic        pad_a      [2];
    logic [15:0] blocks_a   [2];

    int n_pass  = 0;
    int n_total = 0;
    vec_t vecs [6];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    rs_enc_framer #(.K(8), .PAD_BYTE(8'h00)) dut8 (
        .core_clk(clk), .rst_n(rst_n_a[0]),
        .input_tdata(in_data_a[0]), .input_tvalid(in_valid_a[0]), .input_tlast(in_last_a[0]),
        .input_tready(in_ready_a[0]),
        .m_axis_tdata(m_data_a[0]), .m_axis_tvalid(m_valid_a[0]), .m_axis_tlast(m_last_a[0]),
        .m_axis_tready(m_ready_a[0]),
        .pad_active(pad_a[0]), .blocks_sent(blocks_a[0])
    );

    rs_enc_framer #(.K(6), .PAD_BYTE(8'h00)) dut6 (
        .core_clk(clk), .rst_n(rst_n_a[1]),
        .input_tdata(in_data_a[1]), .input_tvalid(in_valid_a[1]), .input_tlast(in_last_a[1]),
        .input_tready(in_ready_a[1]),
        .m_axis_tdata(m_data_a[1]), .m_axis_tvalid(m_valid_a[1]), .m_axis_tlast(m_last_a[1]),
        .m_axis_tready(m_ready_a[1]),
        .pad_active(pad_a[1]), .blocks_sent(blocks_a[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply_reset(input int d);
        rst_n_a[d]    = 1'b0;
        in_valid_a[d] = 1'b0;
        in_last_a[d]  = 1'b0;
        in_data_a[d]  = 32'h0;
        m_ready_a[d]  = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n_a[d] = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input int vi, input bit do_reset);
        vec_t v;
        int d, widx, bidx, cyc;
        bit acc, stall;
        logic [7:0] pdata;
        logic plast;
        v = vecs[vi];
        d = v.dut;
        if (do_reset) apply_reset(d);
        widx = 0; bidx = 0; cyc = 0; stall = 1'b0; pdata = 8'h00; plast = 1'b0;
        while (bidx < v.nbytes && cyc < 300) begin
            in_valid_a[d] = (widx < v.nwords);
            in_data_a[d]  = (widx < v.nwords) ? v.w[widx] : 32'h0;
            in_last_a[d]  = v.msg_last && (widx == v.nwords - 1);
            m_ready_a[d]  = v.rdy_pat[cyc % 4];
            @(negedge clk);
            acc = in_valid_a[d] && in_ready_a[d];
            if (stall) begin
                check($sformatf("v%0d stall_valid b%0d", vi, bidx), {31'b0, m_valid_a[d]}, 32'h1);
                check($sformatf("v%0d stall_data b%0d", vi, bidx), {24'b0, m_data_a[d]}, {24'b0, pdata});
                check($sformatf("v%0d stall_last b%0d", vi, bidx), {31'b0, m_last_a[d]}, {31'b0, plast});
            end
            if (pad_a[d]) check($sformatf("v%0d pad_tready b%0d", vi, bidx), {31'b0, in_ready_a[d]}, 32'h0);
            if (v.no_gap && bidx > 0) check($sformatf("v%0d no_gap b%0d", vi, bidx), {31'b0, m_valid_a[d]}, 32'h1);
            if (m_valid_a[d] && m_ready_a[d]) begin
                check($sformatf("v%0d data b%0d", vi, bidx), {24'b0, m_data_a[d]}, {24'b0, v.exp_b[bidx]});
                check($sformatf("v%0d last b%0d", vi, bidx), {31'b0, m_last_a[d]}, {31'b0, v.exp_last[bidx]});
                check($sformatf("v%0d pad b%0d", vi, bidx), {31'b0, pad_a[d]}, {31'b0, v.exp_pad[bidx]});
                bidx++;
                stall = 1'b0;
            end else begin
                stall = m_valid_a[d];
                pdata = m_data_a[d];
                plast = m_last_a[d];
            end
            @(posedge clk);
            #1;
            if (acc) widx++;
            cyc++;
        end
        in_valid_a[d] = 1'b0;
        in_last_a[d]  = 1'b0;
        m_ready_a[d]  = 1'b1;
        if (cyc >= 300) check($sformatf("v%0d timeout bytes", vi), bidx, v.nbytes);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check($sformatf("v%0d words_taken", vi), widx, v.nwords);
        check($sformatf("v%0d blocks_sent", vi), {16'b0, blocks_a[d]}, v.exp_blocks);
        check($sformatf("v%0d idle_after", vi), {31'b0, m_valid_a[d]}, 32'h0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 6; i++) begin
            vecs[i].dut = 0; vecs[i].nwords = 0; vecs[i].w = '0; vecs[i].msg_last = 1'b1;
            vecs[i].rdy_pat = 4'b1111; vecs[i].nbytes = 0; vecs[i].exp_b = '0;
            vecs[i].exp_last = 32'h0; vecs[i].exp_pad = 32'h0; vecs[i].exp_blocks = 0;
            vecs[i].no_gap = 1'b0;
        end
        // Case 1: two words, ends exactly on the K=8 boundary.
        vecs[0].nwords = 2; vecs[0].w[0] = 32'h44332211; vecs[0].w[1] = 32'h88776655;
        vecs[0].nbytes = 8; vecs[0].exp_b[7:0] = 64'h8877665544332211;
        vecs[0].exp_last = 32'h80; vecs[0].exp_blocks = 1;
        // Case 2: single word, four pad bytes.
        vecs[1].nwords = 1; vecs[1].w[0] = 32'hDDCCBBAA;
        vecs[1].nbytes = 8; vecs[1].exp_b[7:0] = 64'h00000000DDCCBBAA;
        vecs[1].exp_last = 32'h80; vecs[1].exp_pad = 32'hF0; vecs[1].exp_blocks = 1;
        // Case 3: K=6, blocks straddle words.
        vecs[2].dut = 1; vecs[2].nwords = 3;
        vecs[2].w[0] = 32'h04030201; vecs[2].w[1] = 32'h08070605; vecs[2].w[2] = 32'h0C0B0A09;
        vecs[2].nbytes = 12; vecs[2].exp_b[11:0] = 96'h0C0B0A090807060504030201;
        vecs[2].exp_last = 32'h820; vecs[2].exp_blocks = 2;
        // Case 4: case 1 under backpressure 1,0,0,1.
        vecs[3] = vecs[0]; vecs[3].rdy_pat = 4'b1001;
        // Case 6: eight back-to-back words, no message end.
        vecs[4].nwords = 8; vecs[4].msg_last = 1'b0; vecs[4].nbytes = 32;
        vecs[4].exp_last = 32'h80808080; vecs[4].exp_blocks = 4; vecs[4].no_gap = 1'b1;
        for (int i = 0; i < 8; i++) vecs[4].w[i] = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
        for (int i = 0; i < 32; i++) vecs[4].exp_b[i] = 8'(i);
        // K=6 single word: two pad bytes, tlast on the second.
        vecs[5].dut = 1; vecs[5].nwords = 1; vecs[5].w[0] = 32'h44332211;
        vecs[5].nbytes = 6; vecs[5].exp_b[5:0] = 48'h000044332211;
        vecs[5].exp_last = 32'h20; vecs[5].exp_pad = 32'h30; vecs[5].exp_blocks = 1;

        for (int d = 0; d < 2; d++) begin
            rst_n_a[d] = 1'b0; in_valid_a[d] = 1'b0; in_last_a[d] = 1'b0;
            in_data_a[d] = 32'h0; m_ready_a[d] = 1'b1;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst%0d tvalid", d), {31'b0, m_valid_a[d]}, 32'h0);
            check($sformatf("rst%0d tlast", d), {31'b0, m_last_a[d]}, 32'h0);
            check($sformatf("rst%0d tdata", d), {24'b0, m_data_a[d]}, 32'h0);
            check($sformatf("rst%0d pad", d), {31'b0, pad_a[d]}, 32'h0);
            check($sformatf("rst%0d blocks", d), {16'b0, blocks_a[d]}, 32'h0);
            check($sformatf("rst%0d in_ready", d), {31'b0, in_ready_a[d]}, 32'h0);
        end

        for (int i = 0; i < 6; i++) run_vec(i, 1'b1);

        // Reset asserted while the second pad byte of case 2 is on the bus.
        apply_reset(0);
        in_valid_a[0] = 1'b1; in_data_a[0] = 32'hDDCCBBAA; in_last_a[0] = 1'b1;
        @(posedge clk);
        #1;
        in_valid_a[0] = 1'b0; in_last_a[0] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("midpad pad_active", {31'b0, pad_a[0]}, 32'h1);
        check("midpad tvalid", {31'b0, m_valid_a[0]}, 32'h1);
        rst_n_a[0] = 1'b0;
        #1;
        check("midpad_rst tvalid", {31'b0, m_valid_a[0]}, 32'h0);
        check("midpad_rst pad", {31'b0, pad_a[0]}, 32'h0);
        @(posedge clk);
        #1;
        check("midpad_rst edge tvalid", {31'b0, m_valid_a[0]}, 32'h0);
        check("midpad_rst edge tlast", {31'b0, m_last_a[0]}, 32'h0);
        check("midpad_rst edge blocks", {16'b0, blocks_a[0]}, 32'h0);
        @(negedge clk);
        rst_n_a[0] = 1'b1;
        @(posedge clk);
        #1;
        run_vec(0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
